// File: rtl/rle_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rle_decode
// Purpose  : Run-length decoder. It reads packed (byte, count) pairs from the
//            shared SRAM, two pairs per 32-bit word with the earlier pair in
//            the low half. It expands each pair into `count` copies of `byte`
//            and writes the result back through the same port, packing four
//            bytes per word big-endian.
// Ports    : clk             - single clock (also forwarded as port_A_clk)
//            nreset          - synchronous reset, active-high
//            start           - decode request, honoured in IDLE/DONE only
//            rle_addr        - byte address of first compressed word
//            rle_size        - compressed length in bytes (even)
//            message_addr    - byte address of decoded output
//            port_A_data_out - SRAM read data
//            message_size    - decoded length in bytes (valid with done)
//            done            - decode complete
//            port_A_clk/addr/data_in/we - SRAM port A
// Revision : 1.0 - initial release
// ============================================================================
module rle_decode (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] message_addr,
    input  logic [31:0] port_A_data_out,
    output logic [31:0] message_size,
    output logic        done,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic [31:0] port_A_data_in,
    output logic        port_A_we
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_WAIT = 3'd2,
        S_LOAD    = 3'd3,
        S_EXPAND  = 3'd4,
        S_WR      = 3'd5,
        S_FLUSH   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    state_t      r_resume;      // where WR returns to once the word is out
    state_t      w_after;       // successor once the current pair ends
    state_t      w_expand_next;

    logic [31:0] r_rd_ptr;
    logic [31:0] r_wr_ptr;
    logic [31:0] r_rle_size;
    logic [31:0] r_used;        // compressed bytes consumed before current pair
    logic [31:0] r_word;
    logic [31:0] r_pack;
    logic [31:0] r_msg_size;
    logic        r_half;        // 0 = low pair of r_word, 1 = high pair
    logic [7:0]  r_count;       // copies still to emit for the current pair
    logic [1:0]  r_lane;

    logic        w_start_ok;
    logic [7:0]  w_cur_byte;
    logic [31:0] w_pack_next;

    // Pair scanner: starting at a given half of a word, finds the next pair
    // with a non-zero count so zero-count pairs cost no cycles.
    // w_scan_start: 0 = try low pair first, 1 = high pair only, 2 = none left.
    logic [31:0] w_scan_word;
    logic [1:0]  w_scan_start;
    logic [31:0] w_scan_used_in;
    logic [31:0] w_scan_used;
    logic        w_found;
    logic        w_found_half;
    logic [7:0]  w_found_count;

    // Only the low 16 pointer bits reach the port; the rest just wrap.
    logic        w_unused;
    assign w_unused = ^{r_rd_ptr[31:16], r_wr_ptr[31:16]};

    assign port_A_clk   = clk;
    assign done         = (r_state == S_DONE);
    assign message_size = r_msg_size;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cur_byte  = r_half ? r_word[31:24] : r_word[15:8];
    // Lane 0 lands in [31:24]; (3 - lane) equals ~lane for a 2-bit lane.
    assign w_pack_next = r_pack | ({24'h0, w_cur_byte} << {~r_lane, 3'b000});

    // Scanner input selection
    always_comb begin
        w_scan_word    = r_word;
        w_scan_start   = 2'd2;
        w_scan_used_in = r_used + 32'd2;
        if (r_state == S_LOAD) begin
            w_scan_word    = port_A_data_out;
            w_scan_start   = 2'd0;
            w_scan_used_in = r_used;
        end else if (!r_half) begin
            w_scan_start = 2'd1;
        end
    end

    // Pair scanner
    always_comb begin
        w_found      = 1'b0;
        w_found_half = 1'b0;
        w_scan_used  = w_scan_used_in;
        if (w_scan_start == 2'd0) begin
            if (w_scan_word[7:0] != 8'd0) begin
                w_found = 1'b1;
            end else begin
                w_scan_used = w_scan_used + 32'd2;
            end
        end
        // The high pair exists only while compressed bytes remain.
        if (!w_found && (w_scan_start != 2'd2) && (w_scan_used < r_rle_size)) begin
            if (w_scan_word[23:16] != 8'd0) begin
                w_found      = 1'b1;
                w_found_half = 1'b1;
            end else begin
                w_scan_used = w_scan_used + 32'd2;
            end
        end
        w_found_count = w_found_half ? w_scan_word[23:16] : w_scan_word[7:0];
        if (w_found) begin
            w_after = S_EXPAND;
        end else if (w_scan_used >= r_rle_size) begin
            w_after = S_FLUSH;
        end else begin
            w_after = S_RD_ADDR;
        end
        w_expand_next = (r_count == 8'd1) ? w_after : S_EXPAND;
    end

    // State register
    always_ff @(posedge clk) begin
        if (nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and SRAM port drive
    always_comb begin
        w_state_next   = r_state;
        port_A_we      = 1'b0;
        port_A_addr    = 16'h0;
        port_A_data_in = 32'h0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (rle_size == 32'd0) ? S_DONE : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                port_A_addr  = r_rd_ptr[15:0];
                w_state_next = S_RD_WAIT;
            end
            // Address held through the wait and capture cycles so the SRAM
            // output stays on the same word until it is latched.
            S_RD_WAIT: begin
                port_A_addr  = r_rd_ptr[15:0];
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                port_A_addr  = r_rd_ptr[15:0];
                w_state_next = w_after;
            end
            S_EXPAND: begin
                w_state_next = (r_lane == 2'd3) ? S_WR : w_expand_next;
            end
            S_WR: begin
                port_A_we      = 1'b1;
                port_A_addr    = r_wr_ptr[15:0];
                port_A_data_in = r_pack;
                w_state_next   = r_resume;
            end
            S_FLUSH: begin
                if (r_lane != 2'd0) begin
                    port_A_we      = 1'b1;
                    port_A_addr    = r_wr_ptr[15:0];
                    port_A_data_in = r_pack;
                end
                w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (nreset) begin
            r_rd_ptr   <= 32'h0;
            r_wr_ptr   <= 32'h0;
            r_rle_size <= 32'h0;
            r_used     <= 32'h0;
            r_word     <= 32'h0;
            r_pack     <= 32'h0;
            r_msg_size <= 32'h0;
            r_half     <= 1'b0;
            r_count    <= 8'h0;
            r_lane     <= 2'd0;
            r_resume   <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_rd_ptr   <= rle_addr;
                        r_wr_ptr   <= message_addr;
                        r_rle_size <= rle_size;
                        r_used     <= 32'h0;
                        r_pack     <= 32'h0;
                        r_msg_size <= 32'h0;
                        r_lane     <= 2'd0;
                    end
                end
                S_LOAD: begin
                    r_word   <= port_A_data_out;
                    r_rd_ptr <= r_rd_ptr + 32'd4;
                    r_used   <= w_scan_used;
                    r_half   <= w_found_half;
                    r_count  <= w_found_count;
                end
                S_EXPAND: begin
                    r_pack     <= w_pack_next;
                    r_lane     <= r_lane + 2'd1;
                    r_msg_size <= r_msg_size + 32'd1;
                    r_resume   <= w_expand_next;
                    if (r_count == 8'd1) begin
                        r_used  <= w_scan_used;
                        r_half  <= w_found_half;
                        r_count <= w_found_count;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                S_WR: begin
                    r_wr_ptr <= r_wr_ptr + 32'd4;
                    r_pack   <= 32'h0;
                    r_lane   <= 2'd0;
                end
                S_FLUSH: begin
                    if (r_lane != 2'd0) begin
                        r_wr_ptr <= r_wr_ptr + 32'd4;
                        r_pack   <= 32'h0;
                        r_lane   <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rle_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rle_decode
// Purpose  : Directed bench for rle_decode with a one-cycle-latency SRAM
//            model and a log of every port A write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rle_decode;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic [31:0] message_addr;
    logic [31:0] port_A_data_out;
    logic [31:0] message_size;
    logic        done;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in;
    logic        port_A_we;

    int n_checks = 0;
    int n_errors = 0;

    rle_decode u_dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .message_addr    (message_addr),
        .port_A_data_out (port_A_data_out),
        .message_size    (message_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_data_in  (port_A_data_in),
        .port_A_we       (port_A_we)
    );

    always #5 clk = ~clk;

    // SRAM model plus preload path and write log
    logic [31:0] mem [0:16383];
    logic        pl_we = 1'b0;
    logic [13:0] pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(posedge port_A_clk) begin
        if (pl_we) begin
            mem[pl_idx] <= pl_data;
        end else if (port_A_we) begin
            mem[port_A_addr[15:2]] <= port_A_data_in;
        end
        if (port_A_we) begin
            wa_q.push_back(port_A_addr);
            wd_q.push_back(port_A_data_in);
        end
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_idx  = addr[15:2];
        pl_data = data;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] s, input logic [31:0] m);
        @(negedge clk);
        rle_addr     = a;
        rle_size     = s;
        message_addr = m;
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_reached", {31'h0, done}, 32'h1);
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [15:0] ea, input logic [31:0] ed);
        if (i < wa_q.size()) begin
            chk({tag, "_addr"}, {16'h0, wa_q[i]}, {16'h0, ea});
            chk({tag, "_data"}, wd_q[i], ed);
        end else begin
            chk({tag, "_missing"}, 32'h0, 32'h1);
        end
    endtask

    initial begin
        int cyc;
        int bad;
        nreset       = 1'b1;
        start        = 1'b0;
        rle_addr     = '0;
        rle_size     = '0;
        message_addr = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_we", {31'h0, port_A_we}, 32'h0);
        chk("rst_addr", {16'h0, port_A_addr}, 32'h0);
        chk("rst_din", port_A_data_in, 32'h0);
        chk("rst_msize", message_size, 32'h0);
        nreset = 1'b0;

        preload(16'h0000, 32'h42024103);
        preload(16'h0200, 32'hFFFF5A04);
        preload(16'h0400, 32'h220011FF);
        preload(16'h0600, 32'h43014202);
        preload(16'h0604, 32'hDEAD4403);
        preload(16'h0700, 32'h55030000);

        // AAABB
        launch(32'h0000, 32'd4, 32'h0100);
        wait_done(cyc);
        chk("aaabb_msize", message_size, 32'd5);
        chk("aaabb_nwr", wa_q.size(), 32'd2);
        chk_wr("aaabb_w0", 0, 16'h0100, 32'h41414142);
        chk_wr("aaabb_w1", 1, 16'h0104, 32'h42000000);
        repeat (5) @(negedge clk);
        chk("aaabb_done_hold", {31'h0, done}, 32'h1);
        chk("aaabb_msize_hold", message_size, 32'd5);

        // Single pair, exactly one full word, no flush write
        launch(32'h0200, 32'd2, 32'h0300);
        wait_done(cyc);
        chk("single_msize", message_size, 32'd4);
        chk("single_nwr", wa_q.size(), 32'd1);
        chk_wr("single_w0", 0, 16'h0300, 32'h5A5A5A5A);

        // Long run followed by a zero-count pair
        launch(32'h0400, 32'd4, 32'h1000);
        wait_done(cyc);
        chk("long_msize", message_size, 32'd255);
        chk("long_nwr", wa_q.size(), 32'd64);
        bad = 0;
        for (int i = 0; i < 63 && i < wa_q.size(); i++) begin
            if (wd_q[i] !== 32'h11111111 || wa_q[i] !== 16'h1000 + 16'(4 * i)) bad++;
        end
        chk("long_body_bad", bad, 32'd0);
        chk_wr("long_tail", 63, 16'h10FC, 32'h11111100);

        // Two words, odd pair count: high half of last word ignored
        launch(32'h0600, 32'd6, 32'h2000);
        wait_done(cyc);
        chk("two_msize", message_size, 32'd6);
        chk("two_nwr", wa_q.size(), 32'd2);
        chk_wr("two_w0", 0, 16'h2000, 32'h42424344);
        chk_wr("two_w1", 1, 16'h2004, 32'h44440000);

        // Leading zero-count pair skipped
        launch(32'h0700, 32'd4, 32'h3000);
        wait_done(cyc);
        chk("zlead_msize", message_size, 32'd3);
        chk("zlead_nwr", wa_q.size(), 32'd1);
        chk_wr("zlead_w0", 0, 16'h3000, 32'h55555500);

        // Empty input from IDLE
        nreset = 1'b1;
        @(negedge clk);
        nreset = 1'b0;
        launch(32'h0000, 32'd0, 32'h4000);
        wait_done(cyc);
        chk("empty_latency_ok", {31'h0, (cyc <= 2)}, 32'h1);
        chk("empty_msize", message_size, 32'd0);
        chk("empty_nwr", wa_q.size(), 32'd0);

        // Reset in the middle of AAABB, right after the first write
        launch(32'h0000, 32'd4, 32'h0500);
        cyc = 0;
        while (wa_q.size() < 1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_first_wr", wa_q.size(), 32'd1);
        nreset = 1'b1;
        @(negedge clk);
        chk("midrst_done", {31'h0, done}, 32'h0);
        chk("midrst_we", {31'h0, port_A_we}, 32'h0);
        chk("midrst_addr", {16'h0, port_A_addr}, 32'h0);
        chk("midrst_din", port_A_data_in, 32'h0);
        chk("midrst_msize", message_size, 32'd0);
        nreset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_more_wr", wa_q.size(), 32'd1);

        // Redecode; a start with different arguments during EXPAND is ignored
        launch(32'h0000, 32'd4, 32'h0500);
        repeat (3) @(negedge clk);
        rle_addr     = 32'h0200;
        rle_size     = 32'd0;
        message_addr = 32'h6000;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_done(cyc);
        chk("redo_msize", message_size, 32'd5);
        chk("redo_nwr", wa_q.size(), 32'd2);
        chk_wr("redo_w0", 0, 16'h0500, 32'h41414142);
        chk_wr("redo_w1", 1, 16'h0504, 32'h42000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
